// File: rtl/vram_sched_pkg.sv
// Shared types and defaults for the VRAM slot scheduler.
package vram_sched_pkg;

   localparam int unsigned MemLatDefault  = 2;
   localparam int unsigned CpuSlotDefault = 5;

   typedef enum logic [2:0] {StIdle, StVid, StCpu, StLat, StDone} state_e;

   // Who owns the access in flight; OwnDrain is a posted write with no requester waiting.
   typedef enum logic [1:0] {OwnVid, OwnCpu, OwnDrain} owner_e;

endpackage

// File: rtl/vram_wrbuf.sv
// One-entry CPU write post buffer; only built when VRAM_SCHED_WRBUF_EN is defined.
module vram_wrbuf (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        push,
   input  logic [17:0] push_word,
   input  logic [7:0]  push_data,
   input  logic        pop,
   input  logic [17:0] rd_word,
   output logic        valid,
   output logic [17:0] word,
   output logic [7:0]  data,
   output logic        hit
);

   logic        valid_q;
   logic [17:0] word_q;
   logic [7:0]  data_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         data_q  <= '0;
      end else if (push) begin
         valid_q <= 1'b1;
         word_q  <= push_word;
         data_q  <= push_data;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   assign valid = valid_q;
   assign word  = word_q;
   assign data  = data_q;
   assign hit   = valid_q && (word_q == rd_word);

endmodule

// File: rtl/vram_sched.sv
// Single-port VRAM arbiter between video fetch and Z80 access, granted on pixel slots.
// Optional posted CPU writes: define VRAM_SCHED_WRBUF_EN.
module vram_sched
   import vram_sched_pkg::*;
#(
   parameter int unsigned MEM_LAT  = MemLatDefault,
   parameter int unsigned CPU_SLOT = CpuSlotDefault
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_6mp,
   input  logic [2:0]  hc_phase,
   input  logic        contention,
   input  logic        vid_req,
   input  logic [18:0] vid_addr,
   output logic        vid_ack,
   output logic [15:0] vid_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [18:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic        cpu_ack,
   output logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   output logic [18:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_we,
   output logic [7:0]  mem_din,
   input  logic [15:0] mem_dout
);

   localparam logic [2:0] LatLast  = MEM_LAT[2:0];
   localparam logic [2:0] CpuPhase = CPU_SLOT[2:0];

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [18:0] mem_addr_q, mem_addr_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_we_q, mem_we_d;
   logic [7:0]  mem_din_q, mem_din_d;
   logic        cpu_a0_q, cpu_a0_d;
   logic        cpu_wr_q, cpu_wr_d;
   logic [15:0] vid_data_q, vid_data_d;
   logic [7:0]  cpu_dout_q, cpu_dout_d;

   logic        cpu_slot_ok;
   logic        cpu_go;
   logic        drain_go;
   logic        wb_ack;
   logic [17:0] wb_word;
   logic [7:0]  wb_data;

   assign cpu_slot_ok = !contention || (hc_phase == CpuPhase);

`ifdef VRAM_SCHED_WRBUF_EN
   logic wb_valid, wb_hit, wb_push, wb_pop, wb_ack_q;

   assign wb_push  = cpu_req && cpu_we && !wb_valid && !wb_ack_q;
   assign wb_pop   = (state_q == StIdle) && ce_6mp && !vid_req && cpu_slot_ok && wb_valid;
   assign drain_go = wb_valid;
   // A read to the buffered word must see the drained data, so it waits behind the drain.
   assign cpu_go   = cpu_req && !cpu_we && !wb_hit && !wb_ack_q;
   assign wb_ack   = wb_ack_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) wb_ack_q <= 1'b0;
      else       wb_ack_q <= wb_push;
   end

   vram_wrbuf u_wrbuf (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (wb_push),
      .push_word (cpu_addr[18:1]),
      .push_data (cpu_din),
      .pop       (wb_pop),
      .rd_word   (cpu_addr[18:1]),
      .valid     (wb_valid),
      .word      (wb_word),
      .data      (wb_data),
      .hit       (wb_hit)
   );

   assign cpu_wait = cpu_req && !cpu_ack && !wb_push;
`else
   assign drain_go = 1'b0;
   assign cpu_go   = cpu_req;
   assign wb_ack   = 1'b0;
   assign wb_word  = '0;
   assign wb_data  = '0;
   assign cpu_wait = cpu_req && !cpu_ack;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         owner_q    <= OwnVid;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_din_q  <= '0;
         cpu_a0_q   <= 1'b0;
         cpu_wr_q   <= 1'b0;
         vid_data_q <= '0;
         cpu_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         mem_we_q   <= mem_we_d;
         mem_din_q  <= mem_din_d;
         cpu_a0_q   <= cpu_a0_d;
         cpu_wr_q   <= cpu_wr_d;
         vid_data_q <= vid_data_d;
         cpu_dout_q <= cpu_dout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_din_d  = mem_din_q;
      cpu_a0_d   = cpu_a0_q;
      cpu_wr_d   = cpu_wr_q;
      vid_data_d = vid_data_q;
      cpu_dout_d = cpu_dout_q;

      unique case (state_q)
         StIdle: begin
            if (ce_6mp) begin
               if (vid_req) begin
                  state_d    = StVid;
                  owner_d    = OwnVid;
                  mem_addr_d = vid_addr;
                  mem_rd_d   = 1'b1;
               end else if (cpu_slot_ok && drain_go) begin
                  state_d    = StCpu;
                  owner_d    = OwnDrain;
                  mem_addr_d = {1'b0, wb_word};
                  mem_din_d  = wb_data;
                  mem_we_d   = 1'b1;
               end else if (cpu_slot_ok && cpu_go) begin
                  state_d    = StCpu;
                  owner_d    = OwnCpu;
                  mem_addr_d = {1'b0, cpu_addr[18:1]};
                  mem_din_d  = cpu_din;
                  mem_we_d   = cpu_we;
                  mem_rd_d   = !cpu_we;
                  cpu_a0_d   = cpu_addr[0];
                  cpu_wr_d   = cpu_we;
               end
            end
         end
         StVid, StCpu: begin
            state_d = StLat;
            cnt_d   = 3'd1;
         end
         StLat: begin
            if (cnt_q >= LatLast) begin
               state_d = StDone;
               if (owner_q == OwnVid) begin
                  vid_data_d = mem_dout;
               end else if (owner_q == OwnCpu && !cpu_wr_q) begin
                  cpu_dout_d = cpu_a0_q ? mem_dout[15:8] : mem_dout[7:0];
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign vid_ack  = (state_q == StDone) && (owner_q == OwnVid);
   assign cpu_ack  = ((state_q == StDone) && (owner_q == OwnCpu)) || wb_ack;
   assign vid_data = vid_data_q;
   assign cpu_dout = cpu_dout_q;
   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign mem_we   = mem_we_q;
   assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_vram_sched.sv
// Directed bench for vram_sched with a latency-accurate VRAM model.
module tb_vram_sched;

   localparam int unsigned MemLat = 2;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce_6mp;
   logic [2:0]  hc_phase;
   logic        contention;
   logic        vid_req;
   logic [18:0] vid_addr;
   logic        vid_ack;
   logic [15:0] vid_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_ack;
   logic [7:0]  cpu_dout;
   logic        cpu_wait;
   logic [18:0] mem_addr;
   logic        mem_rd;
   logic        mem_we;
   logic [7:0]  mem_din;
   logic [15:0] mem_dout;

   int checks   = 0;
   int failures = 0;
   int n;
   logic [15:0] mem_word;
   int          lat_left;
   logic        wait_gap;
   logic        seen;

   vram_sched #(.MEM_LAT(MemLat), .CPU_SLOT(5)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ce_6mp     (ce_6mp),
      .hc_phase   (hc_phase),
      .contention (contention),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_ack    (vid_ack),
      .vid_data   (vid_data),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_ack    (cpu_ack),
      .cpu_dout   (cpu_dout),
      .cpu_wait   (cpu_wait),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_we     (mem_we),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Read data becomes valid MemLat cycles after the cycle mem_rd is high.
   always @(posedge clk_sys) begin
      if (mem_rd) begin
         if (MemLat == 1) begin
            mem_dout <= mem_word;
         end else begin
            mem_dout <= 16'hDEAD;
            lat_left <= MemLat - 1;
         end
      end else if (lat_left == 1) begin
         mem_dout <= mem_word;
         lat_left <= 0;
      end else if (lat_left > 1) begin
         lat_left <= lat_left - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Ticks until the selected ack is seen; n = ticks taken, 99 on timeout.
   task automatic wait_ack(input bit want_cpu);
      n = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (!(want_cpu ? cpu_ack : vid_ack) && cpu_req && !cpu_wait) wait_gap = 1'b1;
         if (want_cpu ? cpu_ack : vid_ack) begin
            n = i;
            break;
         end
      end
      if (n == 0) n = 99;
   endtask

   initial begin
      reset = 1'b1; ce_6mp = 1'b0; hc_phase = 3'd0; contention = 1'b0;
      vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_din = '0; mem_word = 16'h0000; mem_dout = 16'h0000;
      lat_left = 0; wait_gap = 1'b0;
      tick(); tick();
      check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
      check("rst_mem_addr", {13'b0, mem_addr}, 32'd0);
      check("rst_vid_data", {16'b0, vid_data}, 32'd0);
      check("rst_cpu_dout", {24'b0, cpu_dout}, 32'd0);
      reset = 1'b0;
      tick();
      check("idle_acks", {30'b0, vid_ack, cpu_ack}, 32'd0);

      // Video read alone
      vid_req = 1'b1; vid_addr = 19'h12345; mem_word = 16'hBEEF; ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("vid_issue", {12'b0, mem_rd, mem_addr}, {12'b0, 1'b1, 19'h12345});
      wait_ack(1'b0);
      check("vid_latency", n, MemLat + 1);
      check("vid_data", {16'b0, vid_data}, 32'h0000BEEF);
      vid_req = 1'b0;
      tick();
      check("vid_ack_one_cycle", {31'b0, vid_ack}, 32'd0);

      // CPU read under contention: only phase 5 is eligible
      contention = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00A01;
      mem_word = 16'h5A3C; wait_gap = 1'b0; seen = 1'b0;
      #1;
      check("cpu_wait_comb", {31'b0, cpu_wait}, 32'd1);
      for (int p = 2; p <= 4; p++) begin
         hc_phase = 3'(p); ce_6mp = 1'b1;
         tick();
         ce_6mp = 1'b0;
         if (mem_rd || mem_we || !cpu_wait) seen = 1'b1;
         tick();
      end
      check("cpu_no_grant_off_slot", {31'b0, seen}, 32'd0);
      hc_phase = 3'd5; ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("cpu_issue", {12'b0, mem_rd, mem_addr}, {12'b0, 1'b1, 19'h00500});
      wait_ack(1'b1);
      check("cpu_latency", n, MemLat + 1);
      check("cpu_wait_held", {31'b0, wait_gap}, 32'd0);
      check("cpu_dout_hi", {24'b0, cpu_dout}, 32'h5A);
      check("cpu_wait_at_ack", {31'b0, cpu_wait}, 32'd0);
      cpu_req = 1'b0;
      tick();

      // Simultaneous requests: video wins, CPU takes the next slot
      contention = 1'b0; vid_req = 1'b1; vid_addr = 19'h00777;
      cpu_req = 1'b1; cpu_addr = 19'h00010; mem_word = 16'h1234; ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("tie_vid_first", {13'b0, mem_addr}, {13'b0, 19'h00777});
      wait_ack(1'b0);
      check("tie_vid_ack", n, MemLat + 1);
      check("tie_cpu_not_acked", {31'b0, cpu_ack}, 32'd0);
      vid_req = 1'b0; mem_word = 16'hC3D2;
      tick();
      ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("tie_cpu_issue", {12'b0, mem_rd, mem_addr}, {12'b0, 1'b1, 19'h00008});
      wait_ack(1'b1);
      check("tie_cpu_latency", n, MemLat + 1);
      check("tie_cpu_dout_lo", {24'b0, cpu_dout}, 32'hD2);
      check("tie_vid_data_held", {16'b0, vid_data}, 32'h00001234);
      cpu_req = 1'b0;
      tick();

      // Reset in the latency phase aborts the access
      vid_req = 1'b1; vid_addr = 19'h00042; ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("rst_mid_mem_rd", {31'b0, mem_rd}, 32'd0);
      check("rst_mid_mem_addr", {13'b0, mem_addr}, 32'd0);
      check("rst_mid_data", {8'b0, vid_data, cpu_dout}, 32'd0);
      tick();
      reset = 1'b0; vid_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (vid_ack || cpu_ack || mem_rd || mem_we) seen = 1'b1;
      end
      check("rst_no_resume", {31'b0, seen}, 32'd0);

`ifndef VRAM_SCHED_WRBUF_EN
      // CPU write without posting: same slot and wait behaviour as a read
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00103; cpu_din = 8'hA5; ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("wr_issue", {3'b0, mem_we, mem_rd, mem_din, mem_addr},
            {3'b0, 1'b1, 1'b0, 8'hA5, 19'h00081});
      wait_ack(1'b1);
      check("wr_latency", n, MemLat + 1);
      check("wr_cpu_dout_held", {24'b0, cpu_dout}, 32'd0);
      cpu_req = 1'b0;
      tick();
`else
      // Posted write acks at once; read of the same word waits for the drain
      contention = 1'b1; hc_phase = 3'd2;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00103; cpu_din = 8'hA5;
      #1;
      check("wb_no_wait", {31'b0, cpu_wait}, 32'd0);
      tick();
      check("wb_fast_ack", {31'b0, cpu_ack}, 32'd1);
      cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00102; mem_word = 16'h77A5;
      hc_phase = 3'd5; ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("wb_drain", {3'b0, mem_we, mem_rd, mem_din, mem_addr},
            {3'b0, 1'b1, 1'b0, 8'hA5, 19'h00081});
      check("wb_read_waits", {31'b0, cpu_wait}, 32'd1);
      tick(); tick(); tick();
      check("wb_drain_no_ack", {31'b0, cpu_ack}, 32'd0);
      ce_6mp = 1'b1;
      tick();
      ce_6mp = 1'b0;
      check("wb_read_issue", {12'b0, mem_rd, mem_addr}, {12'b0, 1'b1, 19'h00081});
      wait_ack(1'b1);
      check("wb_read_latency", n, MemLat + 1);
      check("wb_read_data", {24'b0, cpu_dout}, 32'hA5);
      cpu_req = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vram_sched.md
VRAM_SCHED -- requirements
Module: vram_sched

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning clk_sys cycles from mem_rd/mem_we issue to valid mem_dout (range 1..7).
REQ-002 SHALL have parameter CPU_SLOT, default 5, meaning the hc[2:0] phase at which a CPU access is permitted under contention.
REQ-003 SHALL have port clk_sys, input, 1, the master clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ce_6mp, input, 1, pixel-rate strobe; slot boundary.
REQ-006 SHALL have port hc_phase, input, 3, video horizontal counter hc[2:0].
REQ-007 SHALL have port contention, input, 1, video mem_contention flag.
REQ-008 SHALL have port vid_req / vid_addr, input, 1 / 19, video fetch request and word address.
REQ-009 SHALL have port vid_ack / vid_data, output, 1 / 16, one-cycle completion pulse and fetched word.
REQ-010 SHALL have port cpu_req / cpu_we / cpu_addr / cpu_din, input, 1 / 1 / 19 / 8, CPU access request.
REQ-011 SHALL have port cpu_ack / cpu_dout / cpu_wait, output, 1 / 8 / 1, completion pulse, read byte, Z80 WAIT request.
REQ-012 SHALL have port mem_addr / mem_rd / mem_we / mem_din / mem_dout, out / out / out / out / in, 19 / 1 / 1 / 8 / 16, single shared VRAM port.

Function
REQ-013 SHALL implement FSM states IDLE, VID, CPU, LAT, DONE; one access in flight at a time.
REQ-014 SHALL leave IDLE only on a clk_sys edge where ce_6mp=1; grant evaluated on that edge only.
REQ-015 SHALL grant video whenever vid_req=1 (IDLE->VID); video never waits more than one slot.
REQ-016 SHALL grant CPU (IDLE->CPU) only if vid_req=0 and (contention=0 or hc_phase==CPU_SLOT).
REQ-017 SHALL, on simultaneous vid_req and cpu_req, grant video; CPU retries next eligible slot.
REQ-018 SHALL drive mem_addr and a one-cycle mem_rd or mem_we in VID/CPU, then count MEM_LAT cycles in LAT, then capture mem_dout in DONE.
REQ-019 SHALL pulse vid_ack or cpu_ack for exactly one cycle in DONE, then return to IDLE; total latency grant-to-ack = MEM_LAT+2 cycles.
REQ-020 SHALL return cpu_dout = cpu_addr[0] ? mem_dout[15:8] : mem_dout[7:0], word address = cpu_addr[18:1] zero-extended; writes set byte lanes likewise.
REQ-021 SHALL assert cpu_wait combinationally while cpu_req=1 and cpu_ack=0.
REQ-022 SHALL require requesters to hold req/addr stable until ack; a req dropped mid-access SHALL still complete and ack SHALL still pulse.
REQ-023 SHALL hold vid_data and cpu_dout at last captured value between accesses.
REQ-024 SHALL keep LAT counter width 3 bits; no wrap beyond MEM_LAT.

Reset
REQ-025 SHALL, on reset (including mid-access), abort immediately: state IDLE, mem_rd=mem_we=0, mem_addr=0, mem_din=0, acks 0, vid_data=0, cpu_dout=0, no pending access resumed.

Configuration
REQ-026 SHALL, with VRAM_SCHED_WRBUF_EN defined, include a one-entry CPU write post buffer: CPU write acked 1 cycle after cpu_req if buffer empty (no wait), drained at next CPU-eligible slot; CPU read to buffered address waits until drained.
REQ-027 SHALL, without VRAM_SCHED_WRBUF_EN, treat writes exactly as reads for grant and wait.

Structure
REQ-028 SHALL place FSM state enum, MEM_LAT default and CPU_SLOT default in package vram_sched_pkg.
REQ-029 SHALL implement the post buffer as sub-module vram_wrbuf, instantiated only under VRAM_SCHED_WRBUF_EN.

Verification
REQ-030 SHALL cover: vid_req alone, addr 19'h12345, mem_dout 16'hBEEF -> vid_ack after MEM_LAT+2 cycles, vid_data=16'hBEEF.
REQ-031 SHALL cover: cpu read, contention=1, hc_phase=2 -> no grant until hc_phase=5 slot; cpu_wait high throughout; cpu_dout = high byte when cpu_addr[0]=1.
REQ-032 SHALL cover: vid_req and cpu_req on same slot -> vid_ack first, cpu_ack on next eligible slot.
REQ-033 SHALL cover: reset asserted during LAT -> next cycle mem_rd=0, state IDLE, no ack pulses.
REQ-034 SHALL cover (WRBUF_EN): cpu write 8'hA5 -> cpu_ack in 1 cycle, mem_we later with mem_din=8'hA5; back-to-back read same address waits for drain.
